// File: rtl/idct_vec_merge_ram_pkg.sv
// -----------------------------------------------------------------------------
// idct_vec_merge_ram_pkg
// Shared definitions for the IDCT vector-merge RAM stage: controller state
// encodings and the geometry of the two half-frame buffer RAMs.
// -----------------------------------------------------------------------------
package idct_vec_merge_ram_pkg;

    // Frame controller states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_READ  = 2'd3
    } state_t;

    // Each RAM holds one half frame, N/2 <= 1024 words
    localparam int RAM_AW    = 10;
    localparam int RAM_DEPTH = 1024;

endpackage

// File: rtl/RAM_dct_vecRot.sv
// -----------------------------------------------------------------------------
// RAM_dct_vecRot
// Simple dual-port RAM, RAM_DEPTH x DATA_W, one write port and one read port
// on the same clock. Read data is registered (1-cycle read latency).
// Ports:
//   clk        clock
//   wren       write enable
//   wraddress  write address
//   data       write data
//   rdaddress  read address
//   q          registered read data
// -----------------------------------------------------------------------------
module RAM_dct_vecRot
    import idct_vec_merge_ram_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              wren,
    input  logic [RAM_AW-1:0] wraddress,
    input  logic [DATA_W-1:0] data,
    input  logic [RAM_AW-1:0] rdaddress,
    output logic [DATA_W-1:0] q
);

    logic [DATA_W-1:0] mem [RAM_DEPTH];

    always_ff @(posedge clk) begin
        if (wren) begin
            mem[wraddress] <= data;
        end
        q <= mem[rdaddress];
    end

endmodule

// File: rtl/idct_vec_merge_ram.sv
// -----------------------------------------------------------------------------
// idct_vec_merge_ram
// Collects N/2+1 paired beats {G(i+1), G(N+1-i)} from the inverse rotation
// stage into two half-frame RAMs, then replays the frame as a single serial
// natural-order stream G(1)..G(N) for the IFFT core.
// Ports:
//   clk, rst_n_sync              clock, synchronous active-low reset
//   sink_valid/ready/sop/eop     input handshake and framing (sink_error ignored)
//   sink_real/imag               front component, G(i+1) on beat i
//   sink_real_rev/imag_rev       reversed component, G(N+1-i) on beat i
//   fftpts_in                    frame length N (power of 2, 8..2048)
//   source_valid/sop/eop         output framing; source_ready sampled in WAIT
//   source_real/imag             output sample, source_error tied to zero
//   fftpts_out                   N captured on the accepted sop
// -----------------------------------------------------------------------------
module idct_vec_merge_ram
    import idct_vec_merge_ram_pkg::*;
#(
    parameter int wDataIn  = 16,
    parameter int wDataOut = 16
) (
    input  logic                       clk,
    input  logic                       rst_n_sync,
    input  logic                       sink_valid,
    output logic                       sink_ready,
    input  logic [1:0]                 sink_error,
    input  logic                       sink_sop,
    input  logic                       sink_eop,
    input  logic signed [wDataIn-1:0]  sink_real,
    input  logic signed [wDataIn-1:0]  sink_imag,
    input  logic signed [wDataIn-1:0]  sink_real_rev,
    input  logic signed [wDataIn-1:0]  sink_imag_rev,
    input  logic [11:0]                fftpts_in,
    output logic                       source_valid,
    input  logic                       source_ready,
    output logic [1:0]                 source_error,
    output logic                       source_sop,
    output logic                       source_eop,
    output logic signed [wDataOut-1:0] source_real,
    output logic signed [wDataOut-1:0] source_imag,
    output logic [11:0]                fftpts_out
);

    localparam int WORD_W = 2 * wDataIn;

    state_t            state, state_next;
    logic [11:0]       wr_cnt, rd_cnt;
    logic [11:0]       wr_pts, wr_half, rd_half;
    logic              wr_beat, wren0, wren1, rd_last;
    logic [RAM_AW-1:0] waddr0, waddr1, raddr0, raddr1;
    logic [WORD_W-1:0] wdata0, wdata1, q0, q1, q_sel;
    logic              vld_p0, sop_p0, eop_p0, sel_p0;
    logic              vld_p1, sop_p1, eop_p1, sel_p1;
    logic              unused_sink_error;

    assign unused_sink_error = ^sink_error;
    assign source_error      = 2'b00;

    // ---- Frame controller ----
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (sink_valid && sink_sop) state_next = sink_eop ? ST_WAIT : ST_WRITE;
            ST_WRITE: if (sink_valid && sink_eop) state_next = ST_WAIT;
            ST_WAIT:  if (source_ready)           state_next = ST_READ;
            ST_READ:  if (rd_last)                state_next = ST_IDLE;
            default:                              state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n_sync) begin
            state      <= ST_IDLE;
            sink_ready <= 1'b0;
            fftpts_out <= '0;
            wr_cnt     <= '0;
            rd_cnt     <= '0;
        end else begin
            state      <= state_next;
            sink_ready <= (state_next == ST_IDLE) || (state_next == ST_WRITE);
            if (state == ST_IDLE && sink_valid && sink_sop) begin
                fftpts_out <= fftpts_in;
            end
            // Beats past N/2 still count once so the counter parks at N/2+1
            if (state == ST_WAIT || state == ST_READ) begin
                wr_cnt <= '0;
            end else if (wr_beat && wr_cnt <= wr_half) begin
                wr_cnt <= wr_cnt + 12'd1;
            end
            rd_cnt <= (state == ST_READ && !rd_last) ? rd_cnt + 12'd1 : '0;
        end
    end

    // ---- Write side ----
    // On the sop beat fftpts_out has not been loaded yet, so take N from the port.
    assign wr_pts  = (state == ST_IDLE) ? fftpts_in : fftpts_out;
    assign wr_half = wr_pts >> 1;
    assign wr_beat = sink_valid && ((state == ST_IDLE && sink_sop) || state == ST_WRITE);

    // Front words land on beats 0..N/2-1, reversed words on beats 1..N/2.
    assign wren0  = wr_beat && (wr_cnt < wr_half);
    assign wren1  = wr_beat && (wr_cnt != 12'd0) && (wr_cnt <= wr_half);
    assign waddr0 = wr_cnt[RAM_AW-1:0];
    assign waddr1 = RAM_AW'(wr_cnt - 12'd1);
    assign wdata0 = {sink_real, sink_imag};
    assign wdata1 = {sink_real_rev, sink_imag_rev};

    // ---- Stage p0: read address issue ----
    // RAM1 holds G(N)..G(N/2+1) at addresses 0..N/2-1, so walking it downward
    // from N/2-1 continues the natural order after RAM0 is exhausted.
    assign rd_half = fftpts_out >> 1;
    assign rd_last = (rd_cnt == fftpts_out - 12'd1);
    assign raddr0  = rd_cnt[RAM_AW-1:0];
    assign raddr1  = RAM_AW'(fftpts_out - 12'd1 - rd_cnt);
    assign vld_p0  = (state == ST_READ);
    assign sop_p0  = vld_p0 && (rd_cnt == 12'd0);
    assign eop_p0  = vld_p0 && rd_last;
    assign sel_p0  = (rd_cnt >= rd_half);

    RAM_dct_vecRot #(.DATA_W(WORD_W)) u0 (
        .clk       (clk),
        .wren      (wren0),
        .wraddress (waddr0),
        .data      (wdata0),
        .rdaddress (raddr0),
        .q         (q0)
    );

    RAM_dct_vecRot #(.DATA_W(WORD_W)) u1 (
        .clk       (clk),
        .wren      (wren1),
        .wraddress (waddr1),
        .data      (wdata1),
        .rdaddress (raddr1),
        .q         (q1)
    );

    // ---- Stage p1: RAM q valid, framing delayed to match ----
    assign q_sel = sel_p1 ? q1 : q0;

    always_ff @(posedge clk) begin
        if (!rst_n_sync) begin
            vld_p1 <= 1'b0;
            sop_p1 <= 1'b0;
            eop_p1 <= 1'b0;
            sel_p1 <= 1'b0;
        end else begin
            vld_p1 <= vld_p0;
            sop_p1 <= sop_p0;
            eop_p1 <= eop_p0;
            sel_p1 <= sel_p0;
        end
    end

    // ---- Stage p2: registered output ----
    always_ff @(posedge clk) begin
        if (!rst_n_sync) begin
            source_valid <= 1'b0;
            source_sop   <= 1'b0;
            source_eop   <= 1'b0;
            source_real  <= '0;
            source_imag  <= '0;
        end else begin
            source_valid <= vld_p1;
            source_sop   <= sop_p1;
            source_eop   <= eop_p1;
            if (vld_p1) begin
                source_real <= q_sel[WORD_W-1 -: wDataOut];
                source_imag <= q_sel[wDataOut-1:0];
            end
        end
    end

endmodule
